mips_step_controller: RTL and testbench
=======================================

Name: mips_step_controller

Overview:
- Synthesizable run/step controller sitting directly upstream of the single-cycle mips core.
- Replaces hand-toggled instruction clocking with a clock-enable (core_en) the core qualifies its state updates with.
- Supports free-run for a programmed instruction count and single-step.
- Counts retired instructions; reports busy/done to the board or bench.

Parameters:
- CNT_W, 32, width of instruction limit and retired-instruction counter.
- DEFAULT_LIMIT, 6, limit loaded at reset and used when limit_in is 0.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begin RUN mode.
- step  input  1  one-cycle pulse; execute exactly one instruction.
- abort  input  1  one-cycle pulse; stop RUN at next edge.
- limit_in  input  CNT_W  instruction budget for RUN; sampled on start.
- core_halt  input  1  from core: halt/illegal/end-of-program reached.
- core_en  output  1  clock enable to mips core; one instruction retires per cycle high.
- instr_count  output  CNT_W  total instructions retired since reset/clear.
- busy  output  1  high in RUN or STEP.
- done  output  1  one-cycle pulse on completion of RUN or STEP.
- halted  output  1  sticky; set when core_halt observed, cleared by reset only.

Behaviour:
- Reset (sync, on clock edge with reset=1): state=IDLE; core_en=0, instr_count=0, busy=0, done=0, halted=0, internal budget=DEFAULT_LIMIT, remaining=0. Reset mid-RUN aborts immediately; no done pulse.
- States: IDLE, RUN, STEP, FINISH.
- IDLE:
  - start=1 and halted=0 -> RUN; budget = (limit_in==0 ? DEFAULT_LIMIT : limit_in); remaining=budget.
  - step=1 and halted=0 -> STEP.
  - start and step in same cycle: start wins.
  - halted=1: start/step ignored, stay IDLE.
- RUN:
  - core_en=1 combinationally from state (high every RUN cycle).
  - Each RUN cycle: instr_count += 1, remaining -= 1.
  - remaining==1 this cycle -> FINISH next cycle; exactly budget enables issued.
  - core_halt=1 in a RUN cycle: that instruction still counted; halted<=1; -> FINISH.
  - abort=1: the current cycle's enable is not issued (core_en gated low by abort), no count; -> FINISH.
  - start/step ignored while in RUN.
- STEP: core_en=1 for exactly one cycle; instr_count += 1; core_halt sets halted; -> FINISH.
- FINISH: core_en=0; done=1 for this single cycle; busy=0; -> IDLE.
- busy = (state==RUN || state==STEP).
- Latency: start at edge N -> first core_en high in cycle N+1; done high in cycle N+1+budget.
- instr_count wraps modulo 2^CNT_W silently.
- remaining never underflows: exit to FINISH occurs at remaining==1.

Test Plan:
- Reset then start with limit_in=6 -> core_en high exactly 6 consecutive cycles; done pulses 1 cycle after last enable; instr_count=6; busy low after.
- start with limit_in=0 -> DEFAULT_LIMIT (6) enables issued; instr_count=6.
- Three step pulses spaced 4 cycles apart -> three isolated 1-cycle core_en pulses, three done pulses, instr_count=3.
- start limit_in=17, core_halt asserted on 5th enabled cycle -> 5 enables total; halted=1; done pulse; subsequent start/step produce no core_en.
- start limit_in=10, abort on 4th RUN cycle -> 3 enables, instr_count=3, done pulses next cycle.
- start limit_in=10, reset high in 3rd RUN cycle -> next cycle core_en=0, instr_count=0, no done pulse; start+step in same cycle afterwards -> RUN mode entered.

Source files
------------

// File: rtl/mips_step_controller.sv
// Run/step controller for the single-cycle mips core: gates the core through
// core_en, counts retired instructions and reports busy/done/halted.
module mips_step_controller #(
    parameter int CNT_W         = 32,
    parameter int DEFAULT_LIMIT = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             abort,
    input  logic [CNT_W-1:0] limit_in,
    input  logic             core_halt,
    output logic             core_en,
    output logic [CNT_W-1:0] instr_count,
    output logic             busy,
    output logic             done,
    output logic             halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEF_LIMIT = CNT_W'(DEFAULT_LIMIT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             halted_reg, halted_next;
    logic [CNT_W-1:0] start_budget;

    // A zero limit means "use the default budget".
    assign start_budget = (limit_in == '0) ? DEF_LIMIT : limit_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            count_reg     <= '0;
            halted_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            count_reg     <= count_next;
            halted_reg    <= halted_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        count_next     = count_reg;
        halted_next    = halted_reg;
        core_en        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!halted_reg) begin
                    if (start) begin
                        state_next     = RUN;
                        remaining_next = start_budget;
                    end else if (step) begin
                        state_next = STEP;
                    end
                end
            end

            RUN: begin
                busy = 1'b1;
                // Abort suppresses this cycle's enable, so nothing retires.
                if (abort) begin
                    state_next = FINISH;
                end else begin
                    core_en        = 1'b1;
                    count_next     = count_reg + ONE;
                    remaining_next = remaining_reg - ONE;
                    if (core_halt) begin
                        halted_next = 1'b1;
                        state_next  = FINISH;
                    end else if (remaining_reg == ONE) begin
                        state_next = FINISH;
                    end
                end
            end

            STEP: begin
                busy       = 1'b1;
                core_en    = 1'b1;
                count_next = count_reg + ONE;
                if (core_halt) begin
                    halted_next = 1'b1;
                end
                state_next = FINISH;
            end

            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign instr_count = count_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_mips_step_controller.sv
// Bench for mips_step_controller: directed scenarios followed by random
// run/step/abort/halt/reset transactions, each checked against expected counts.
module tb_mips_step_controller;

    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          step;
    logic          abort;
    logic [CW-1:0] limit_in;
    logic          core_halt;
    logic          core_en;
    logic [CW-1:0] instr_count;
    logic          busy;
    logic          done;
    logic          halted;

    int            tests = 0;
    int            fails = 0;
    logic [CW-1:0] exp_count;
    bit            exp_halted;

    mips_step_controller #(.CNT_W(CW), .DEFAULT_LIMIT(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .step       (step),
        .abort      (abort),
        .limit_in   (limit_in),
        .core_halt  (core_halt),
        .core_en    (core_en),
        .instr_count(instr_count),
        .busy       (busy),
        .done       (done),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_totals(input string tag);
        @(negedge clock);
        check({tag, "_count"}, instr_count, exp_count);
        check({tag, "_halted"}, {31'd0, halted}, {31'd0, exp_halted});
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        exp_count  = '0;
        exp_halted = 1'b0;
        @(negedge clock);
        check("rst_en", {31'd0, core_en}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check_totals("rst");
        $display("[TB] reset: count=%0d halted=%0d", instr_count, halted);
    endtask

    // One RUN transaction. halt_at/abort_at are 1-based RUN-cycle indices (0 = none).
    task automatic do_run(input logic [CW-1:0] lim, input int halt_at, input int abort_at,
                          input bit with_step);
        int n, done_at, b, ens;
        bit hl, ab;
        b  = (lim == 0) ? 6 : int'(lim);
        n  = b;
        hl = 1'b0;
        ab = 1'b0;
        if (halt_at != 0 && halt_at <= n) begin
            n  = halt_at;
            hl = 1'b1;
        end
        if (abort_at != 0 && abort_at <= n) begin
            n  = abort_at - 1;
            hl = 1'b0;
            ab = 1'b1;
        end
        ens      = 0;
        start    = 1'b1;
        step     = with_step;
        limit_in = lim;
        tick();
        start    = 1'b0;
        step     = 1'b0;
        limit_in = $urandom;
        if (exp_halted) begin
            for (int i = 1; i <= 3; i++) begin
                @(negedge clock);
                check("halted_run_en", {31'd0, core_en}, 0);
                check("halted_run_busy", {31'd0, busy}, 0);
                check("halted_run_done", {31'd0, done}, 0);
                tick();
            end
        end else begin
            done_at = ab ? n + 2 : n + 1;
            for (int i = 1; i <= done_at + 1; i++) begin
                abort     = (i == abort_at);
                core_halt = (i == halt_at);
                @(negedge clock);
                check("run_en", {31'd0, core_en}, {31'd0, i <= n});
                check("run_busy", {31'd0, busy}, {31'd0, i < done_at});
                check("run_done", {31'd0, done}, {31'd0, i == done_at});
                if (core_en) ens++;
                tick();
            end
            abort     = 1'b0;
            core_halt = 1'b0;
            exp_count = exp_count + CW'(n);
            if (hl) exp_halted = 1'b1;
        end
        check_totals("run");
        $display("[TB] run lim=%0d halt_at=%0d abort_at=%0d step=%0d enables=%0d count=%0d halted=%0d",
                 lim, halt_at, abort_at, with_step, ens, instr_count, halted);
    endtask

    task automatic do_step(input bit h);
        step = 1'b1;
        tick();
        step = 1'b0;
        if (exp_halted) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clock);
                check("halted_step_en", {31'd0, core_en}, 0);
                check("halted_step_done", {31'd0, done}, 0);
                tick();
            end
        end else begin
            core_halt = h;
            @(negedge clock);
            check("step_en", {31'd0, core_en}, 1);
            check("step_busy", {31'd0, busy}, 1);
            check("step_done0", {31'd0, done}, 0);
            tick();
            core_halt = 1'b0;
            @(negedge clock);
            check("step_en_off", {31'd0, core_en}, 0);
            check("step_done", {31'd0, done}, 1);
            check("step_busy_off", {31'd0, busy}, 0);
            tick();
            @(negedge clock);
            check("step_done_off", {31'd0, done}, 0);
            exp_count = exp_count + CW'(1);
            if (h) exp_halted = 1'b1;
        end
        check_totals("step");
        $display("[TB] step halt=%0d count=%0d halted=%0d", h, instr_count, halted);
    endtask

    // Idle cycles with noise on abort/core_halt: nothing may happen.
    task automatic do_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            abort     = $urandom_range(0, 1);
            core_halt = $urandom_range(0, 1);
            @(negedge clock);
            check("idle_en", {31'd0, core_en}, 0);
            check("idle_busy", {31'd0, busy}, 0);
            check("idle_done", {31'd0, done}, 0);
            tick();
        end
        abort     = 1'b0;
        core_halt = 1'b0;
        check_totals("idle");
        $display("[TB] idle %0d cycles count=%0d", cycles, instr_count);
    endtask

    task automatic do_reset_mid_run;
        start    = 1'b1;
        limit_in = 10;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clock);
            check("mid_en", {31'd0, core_en}, 1);
            tick();
        end
        reset = 1'b1;
        @(negedge clock);
        check("mid_en3", {31'd0, core_en}, 1);
        tick();
        reset      = 1'b0;
        exp_count  = '0;
        exp_halted = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("mid_rst_en", {31'd0, core_en}, 0);
            check("mid_rst_done", {31'd0, done}, 0);
            check("mid_rst_busy", {31'd0, busy}, 0);
            tick();
        end
        check_totals("mid_rst");
        $display("[TB] reset during run: count=%0d", instr_count);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        step      = 1'b0;
        abort     = 1'b0;
        limit_in  = '0;
        core_halt = 1'b0;
        exp_count = '0;
        exp_halted = 1'b0;
        tick();
        do_reset();

        do_run(6, 0, 0, 1'b0);
        do_run(0, 0, 0, 1'b0);
        do_reset();
        do_step(1'b0);
        do_idle(2);
        do_step(1'b0);
        do_idle(2);
        do_step(1'b0);
        do_reset();
        do_run(10, 0, 4, 1'b0);
        do_reset();
        do_run(17, 5, 0, 1'b0);
        do_run(5, 0, 0, 1'b0);
        do_step(1'b0);
        do_idle(2);
        do_reset();
        do_reset_mid_run();
        do_run(8, 0, 0, 1'b1);
        do_run(3, 0, 1, 1'b0);
        do_run(1, 0, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                do_run($urandom_range(0, 12),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0,
                       $urandom_range(0, 1));
            end else if (r < 8) begin
                do_step($urandom_range(0, 5) == 0);
            end else if (r == 8) begin
                do_idle($urandom_range(1, 4));
            end else begin
                do_reset();
            end
            if (exp_halted && $urandom_range(0, 2) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
